// File: rtl/psalm_pkg.sv
// ============================================================================
//  Module      : psalm_pkg
//  Description : Shared stream-controller state encoding, default widths and
//                the end-of-text byte.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package psalm_pkg;

    localparam int          DEF_W    = 11;
    localparam int          DEF_DW   = 8;
    localparam logic [7:0]  EOT_BYTE = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        LATCH = 2'd2,
        SEND  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/psalm_stream_ctrl.sv
// ============================================================================
//  Module      : psalm_stream_ctrl
//  Description : Streams BRAM contents from address 0 to a serial transmitter
//                until the end-of-text byte or the last address. Define
//                PSALM_WRITE_ARB_EN to let an external requester share the
//                memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module psalm_stream_ctrl
    import psalm_pkg::*;
#(
    parameter int             W   = DEF_W,
    parameter int             DW  = DEF_DW,
    parameter logic [DW-1:0]  EOT = DW'(EOT_BYTE)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    output logic          o_busy,
    output logic [W-1:0]  o_mem_addr,
    output logic          o_mem_we,
    output logic [DW-1:0] o_mem_data,
    input  logic [DW-1:0] i_mem_data,
    output logic          o_tx_stb,
    output logic [DW-1:0] o_tx_data,
    input  logic          i_tx_busy,
    input  logic          i_wr_req,
    input  logic [W-1:0]  i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    output logic          o_wr_ack
);

    state_t         r_state,    w_state_nx;
    logic [W-1:0]   r_rd_addr,  w_rd_addr_nx;
    logic           r_pending,  w_pending_nx;
    logic [W-1:0]   r_mem_addr, w_mem_addr_nx;
    logic           r_mem_we,   w_mem_we_nx;
    logic [DW-1:0]  r_mem_data, w_mem_data_nx;
    logic           r_wr_ack,   w_wr_ack_nx;
    logic           r_tx_stb,   w_tx_stb_nx;
    logic [DW-1:0]  r_tx_data,  w_tx_data_nx;

    logic           w_wr_grant;
    logic           w_xfer;
    logic [W-1:0]   w_rd_addr_inc;

`ifdef PSALM_WRITE_ARB_EN
    assign w_wr_grant = i_wr_req && ((r_state == IDLE) || (r_state == SEND));
`else
    logic w_unused_wr;
    assign w_wr_grant  = 1'b0;
    assign w_unused_wr = i_wr_req;
`endif

    assign w_xfer        = r_tx_stb && !i_tx_busy;
    assign w_rd_addr_inc = r_rd_addr + W'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_rd_addr  <= '0;
            r_pending  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_we   <= 1'b0;
            r_mem_data <= '0;
            r_wr_ack   <= 1'b0;
            r_tx_stb   <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_rd_addr  <= w_rd_addr_nx;
            r_pending  <= w_pending_nx;
            r_mem_addr <= w_mem_addr_nx;
            r_mem_we   <= w_mem_we_nx;
            r_mem_data <= w_mem_data_nx;
            r_wr_ack   <= w_wr_ack_nx;
            r_tx_stb   <= w_tx_stb_nx;
            r_tx_data  <= w_tx_data_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_rd_addr_nx  = r_rd_addr;
        w_pending_nx  = r_pending;
        w_mem_addr_nx = r_mem_addr;
        w_mem_we_nx   = 1'b0;
        w_mem_data_nx = r_mem_data;
        w_wr_ack_nx   = 1'b0;
        w_tx_stb_nx   = r_tx_stb;
        w_tx_data_nx  = r_tx_data;

        if (w_wr_grant) begin
            w_mem_we_nx   = 1'b1;
            w_wr_ack_nx   = 1'b1;
            w_mem_addr_nx = i_wr_addr;
            w_mem_data_nx = i_wr_data;
        end

        case (r_state)
            IDLE: begin
                if (i_start || r_pending) begin
                    // A concurrent write owns the port; remember the start.
                    if (w_wr_grant) begin
                        w_pending_nx = 1'b1;
                    end else begin
                        w_pending_nx  = 1'b0;
                        w_rd_addr_nx  = '0;
                        w_mem_addr_nx = '0;
                        w_state_nx    = READ;
                    end
                end
            end
            READ: begin
                w_state_nx = LATCH;
            end
            LATCH: begin
                if (i_mem_data == EOT) begin
                    w_state_nx = IDLE;
                end else begin
                    w_tx_data_nx = i_mem_data;
                    w_tx_stb_nx  = 1'b1;
                    w_state_nx   = SEND;
                end
            end
            SEND: begin
                if (r_tx_stb) begin
                    if (w_xfer) begin
                        w_tx_stb_nx = 1'b0;
                        if (&r_rd_addr) begin
                            w_state_nx = IDLE;
                        end else begin
                            w_rd_addr_nx = w_rd_addr_inc;
                            if (!w_wr_grant) begin
                                w_mem_addr_nx = w_rd_addr_inc;
                                w_state_nx    = READ;
                            end
                        end
                    end
                end else if (!w_wr_grant) begin
                    // Byte already sent, a write held the port: resume reading.
                    w_mem_addr_nx = r_rd_addr;
                    w_state_nx    = READ;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign o_busy     = (r_state != IDLE);
    assign o_mem_addr = r_mem_addr;
    assign o_mem_we   = r_mem_we;
    assign o_mem_data = r_mem_data;
    assign o_wr_ack   = r_wr_ack;
    assign o_tx_stb   = r_tx_stb;
    assign o_tx_data  = r_tx_data;

endmodule

`default_nettype wire

// File: tb/tb_psalm_stream_ctrl.sv
// ============================================================================
//  Module      : tb_psalm_stream_ctrl
//  Description : Self-checking bench for psalm_stream_ctrl (W=11 and W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_psalm_stream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, tx_busy, wr_req;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy, mem_we, tx_stb, wr_ack;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata, tx_data;
    logic        bd_we;
    logic [10:0] bd_addr;
    logic [7:0]  bd_data;
    logic [7:0]  mem [2048];

    logic        start4, busy4, mem_we4, tx_stb4, wr_ack4;
    logic [3:0]  mem_addr4;
    logic [7:0]  mem_wdata4, mem_rdata4, tx_data4;
    logic        bd4_we;
    logic [3:0]  bd4_addr;
    logic [7:0]  bd4_data;
    logic [7:0]  mem4 [16];

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int xfer_cnt = 0, last_cyc = 0, prev_cyc = 0, we_cnt = 0, ack_cnt = 0;
    int xfer4_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp4_q[$];

    psalm_stream_ctrl u_dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .o_busy(busy),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_data(mem_wdata),
        .i_mem_data(mem_rdata), .o_tx_stb(tx_stb), .o_tx_data(tx_data),
        .i_tx_busy(tx_busy), .i_wr_req(wr_req), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .o_wr_ack(wr_ack)
    );

    psalm_stream_ctrl #(.W(4)) u_dut4 (
        .i_clk(clk), .i_reset(rst), .i_start(start4), .o_busy(busy4),
        .o_mem_addr(mem_addr4), .o_mem_we(mem_we4), .o_mem_data(mem_wdata4),
        .i_mem_data(mem_rdata4), .o_tx_stb(tx_stb4), .o_tx_data(tx_data4),
        .i_tx_busy(1'b0), .i_wr_req(1'b0), .i_wr_addr(4'd0),
        .i_wr_data(8'd0), .o_wr_ack(wr_ack4)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (bd_we)  mem[bd_addr]  <= bd_data;
        mem_rdata <= mem[mem_addr];
        if (mem_we4) mem4[mem_addr4] <= mem_wdata4;
        if (bd4_we)  mem4[bd4_addr]  <= bd4_data;
        mem_rdata4 <= mem4[mem_addr4];
    end

    // Scoreboard: every completed transfer pops one expected byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (tx_stb && !tx_busy) begin
            xfer_cnt++;
            prev_cyc = last_cyc;
            last_cyc = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL tx_unexpected: got %h, required no transfer", tx_data);
            end else begin
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    n_bad++;
                    $display("FAIL tx_data: got %h, required %h", tx_data, e);
                end
            end
        end
        if (mem_we) we_cnt++;
        if (wr_ack) ack_cnt++;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (tx_stb4) begin
            xfer4_cnt++;
            n_cmp++;
            if (exp4_q.size() == 0) begin
                n_bad++;
                $display("FAIL tx4_unexpected: got %h, required no transfer", tx_data4);
            end else begin
                e = exp4_q.pop_front();
                if (tx_data4 !== e) begin
                    n_bad++;
                    $display("FAIL tx4_data: got %h, required %h", tx_data4, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [10:0] a, input logic [7:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        tick(1);
        bd_we = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx_stb) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        @(negedge clk);
        n_cmp++;
        if ({busy, tx_stb, mem_we, wr_ack} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b, required 0000", {busy, tx_stb, mem_we, wr_ack});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, tx_data} !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_data: got addr=%h wd=%h tx=%h, required all 0", mem_addr, mem_wdata, tx_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_hi;
        int n0;
        bit ok;
        load(11'd0, 8'h48); load(11'd1, 8'h69); load(11'd2, 8'h00);
        exp_q.push_back(8'h48); exp_q.push_back(8'h69);
        n0 = xfer_cnt;
        start = 1'b1; tick(1); start = 1'b0;
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL hi_idle: got busy, required idle"); end
        n_cmp++;
        if (xfer_cnt - n0 !== 2) begin n_bad++; $display("FAIL hi_count: got %0d, required 2", xfer_cnt - n0); end
        n_cmp++;
        if (last_cyc - prev_cyc !== 3) begin n_bad++; $display("FAIL hi_spacing: got %0d, required 3", last_cyc - prev_cyc); end
        n_cmp++;
        if (exp_q.size() !== 0) begin n_bad++; $display("FAIL hi_left: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_busy_hold;
        int n0;
        bit ok, held;
        exp_q.push_back(8'h48); exp_q.push_back(8'h69);
        n0 = xfer_cnt;
        held = 1'b1;
        tx_busy = 1'b1;
        start = 1'b1; tick(1); start = 1'b0;
        wait_stb(ok);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!(tx_stb === 1'b1 && tx_data === 8'h48)) held = 1'b0;
            if (k < 9) begin @(posedge clk); #1; end
        end
        n_cmp++;
        if (!(ok && held)) begin n_bad++; $display("FAIL hold_stable: got ok=%b held=%b, required 1 1", ok, held); end
        n_cmp++;
        if (xfer_cnt !== n0) begin n_bad++; $display("FAIL hold_noxfer: got %0d, required %0d", xfer_cnt, n0); end
        @(posedge clk); #1;
        tx_busy = 1'b0;
        wait_idle(ok);
        n_cmp++;
        if (!ok || xfer_cnt - n0 !== 2) begin n_bad++; $display("FAIL hold_count: got %0d, required 2", xfer_cnt - n0); end
    endtask

`ifdef PSALM_WRITE_ARB_EN
    task automatic test_write;
        int n0, a0;
        bit ok;
        exp_q.push_back(8'h48); exp_q.push_back(8'h41);
        n0 = xfer_cnt; a0 = ack_cnt;
        start = 1'b1; tick(1); start = 1'b0;
        wait_stb(ok);
        wr_req = 1'b1; wr_addr = 11'd1; wr_data = 8'h41;
        tick(1);
        wr_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_we, wr_ack, tx_stb, busy} !== 4'b1101 || mem_addr !== 11'd1 || mem_wdata !== 8'h41) begin
            n_bad++;
            $display("FAIL wr_cycle: got we/ack/stb/busy=%b addr=%h d=%h, required 1101 001 41",
                     {mem_we, wr_ack, tx_stb, busy}, mem_addr, mem_wdata);
        end
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if ({mem_we, wr_ack, busy} !== 3'b001 || mem_addr !== 11'd1) begin
            n_bad++;
            $display("FAIL wr_resume: got we/ack/busy=%b addr=%h, required 001 001", {mem_we, wr_ack, busy}, mem_addr);
        end
        @(posedge clk); #1;
        wait_idle(ok);
        n_cmp++;
        if (!ok || xfer_cnt - n0 !== 2 || ack_cnt - a0 !== 1) begin
            n_bad++;
            $display("FAIL wr_count: got xfers=%0d acks=%0d, required 2 1", xfer_cnt - n0, ack_cnt - a0);
        end
        n_cmp++;
        if (last_cyc - prev_cyc !== 4) begin n_bad++; $display("FAIL wr_spacing: got %0d, required 4", last_cyc - prev_cyc); end

        // Start and write together in IDLE: write first, READ one cycle later.
        exp_q.push_back(8'h48); exp_q.push_back(8'h69);
        n0 = xfer_cnt;
        start = 1'b1; wr_req = 1'b1; wr_addr = 11'd1; wr_data = 8'h69;
        tick(1);
        start = 1'b0; wr_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_we, wr_ack, busy} !== 3'b110 || mem_addr !== 11'd1) begin
            n_bad++;
            $display("FAIL wrst_write: got we/ack/busy=%b addr=%h, required 110 001", {mem_we, wr_ack, busy}, mem_addr);
        end
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if ({mem_we, busy} !== 2'b01 || mem_addr !== 11'd0) begin
            n_bad++;
            $display("FAIL wrst_read: got we/busy=%b addr=%h, required 01 000", {mem_we, busy}, mem_addr);
        end
        @(posedge clk); #1;
        wait_idle(ok);
        n_cmp++;
        if (!ok || xfer_cnt - n0 !== 2) begin n_bad++; $display("FAIL wrst_count: got %0d, required 2", xfer_cnt - n0); end
    endtask
`else
    task automatic test_no_write;
        int n0, w0, a0;
        bit ok;
        exp_q.push_back(8'h48); exp_q.push_back(8'h69);
        n0 = xfer_cnt; w0 = we_cnt; a0 = ack_cnt;
        wr_req = 1'b1; wr_addr = 11'd1; wr_data = 8'h41;
        start = 1'b1; tick(1); start = 1'b0;
        wait_idle(ok);
        tick(2);
        wr_req = 1'b0;
        n_cmp++;
        if (we_cnt - w0 !== 0 || ack_cnt - a0 !== 0) begin
            n_bad++;
            $display("FAIL nowr_port: got we=%0d ack=%0d, required 0 0", we_cnt - w0, ack_cnt - a0);
        end
        n_cmp++;
        if (!ok || xfer_cnt - n0 !== 2) begin n_bad++; $display("FAIL nowr_count: got %0d, required 2", xfer_cnt - n0); end
        n_cmp++;
        if (last_cyc - prev_cyc !== 3) begin n_bad++; $display("FAIL nowr_spacing: got %0d, required 3", last_cyc - prev_cyc); end
    endtask
`endif

    task automatic test_wrap;
        bit ok;
        for (int i = 0; i < 16; i++) begin
            bd4_addr = 4'(i); bd4_data = 8'h55; bd4_we = 1'b1;
            tick(1);
            exp4_q.push_back(8'h55);
        end
        bd4_we = 1'b0;
        start4 = 1'b1; tick(1); start4 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy4) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (!ok || xfer4_cnt !== 16) begin n_bad++; $display("FAIL wrap_count: got %0d, required 16", xfer4_cnt); end
        tick(10);
        n_cmp++;
        if (xfer4_cnt !== 16 || busy4 !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_nowrap: got xfers=%0d busy=%b, required 16 0", xfer4_cnt, busy4);
        end
    endtask

    task automatic test_reset_mid_send;
        int n0;
        bit ok;
        n0 = xfer_cnt;
        tx_busy = 1'b1;
        start = 1'b1; tick(1); start = 1'b0;
        wait_stb(ok);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (!ok || {tx_stb, busy} !== 2'b00 || mem_addr !== 11'd0) begin
            n_bad++;
            $display("FAIL rst_send: got stb/busy=%b addr=%h, required 00 000", {tx_stb, busy}, mem_addr);
        end
        @(posedge clk); #1;
        tx_busy = 1'b0;
        tick(5);
        n_cmp++;
        if (xfer_cnt !== n0) begin n_bad++; $display("FAIL rst_noxfer: got %0d, required %0d", xfer_cnt, n0); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tx_busy = 1'b0; wr_req = 1'b0;
        wr_addr = '0; wr_data = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        start4 = 1'b0; bd4_we = 1'b0; bd4_addr = '0; bd4_data = '0;
        tick(3);
        test_reset;
        test_hi;
        test_busy_hold;
`ifdef PSALM_WRITE_ARB_EN
        test_write;
`else
        test_no_write;
`endif
        test_wrap;
        test_reset_mid_send;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
